// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Quadrature encoder front end. Synchronises A/B/IDX, decodes Gray-code
//   phase transitions into up/down/hold/clear commands for a counter and
//   keeps a local position count in step with those commands.
//
//   Optional feature macro: GLITCH_FILTER_EN
//     When defined, each synced channel passes through a stability filter
//     that only follows a new level after FILT consecutive differing cycles.
//
// Ports
//   CLK      in   clock, posedge
//   RST      in   asynchronous active-high reset
//   A, B     in   encoder channels (asynchronous)
//   IDX      in   encoder index (asynchronous), rising edge clears position
//   EN       in   count enable (CLK domain)
//   err_clr  in   clears sticky err
//   s        out  command: 0 up, 1 down, 2 hold, 3 clear
//   step     out  one-cycle pulse on up/down
//   dir      out  last step direction (0 up, 1 down)
//   err      out  sticky illegal-transition flag
//   pos      out  position count, modulo 2^n
module quad_step_decoder #(
    parameter int unsigned n    = 16,
    parameter int unsigned FILT = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         A,
    input  logic         B,
    input  logic         IDX,
    input  logic         EN,
    input  logic         err_clr,
    output logic [1:0]   s,
    output logic         step,
    output logic         dir,
    output logic         err,
    output logic [n-1:0] pos
);

    localparam logic [1:0] S_UP    = 2'd0;
    localparam logic [1:0] S_DOWN  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    if (FILT < 2) begin : g_filt_range
        $error("quad_step_decoder: FILT must be >= 2");
    end

    // Two-flop synchroniser, bit order {A, B, IDX}
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] clean_c;

    always_comb begin
        sync1_d = {A, B, IDX};
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILT + 1);

    logic [2:0]            filt_q, filt_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    // Filtered level follows the synced level only after FILT differing cycles
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int ch = 0; ch < 3; ch++) begin
            if (sync2_q[ch] != filt_q[ch]) begin
                if (cnt_q[ch] == CNT_W'(FILT - 1)) begin
                    filt_d[ch] = sync2_q[ch];
                    cnt_d[ch]  = '0;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end else begin
                cnt_d[ch] = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign clean_c = filt_q;
`else
    assign clean_c = sync2_q;
`endif

    // Position of a phase in the forward Gray sequence 00,01,11,10
    function automatic logic [1:0] gray_pos(input logic [1:0] ph);
        return {ph[1], ph[1] ^ ph[0]};
    endfunction

    logic [1:0]   phase_c;
    logic         idx_c;
    logic [1:0]   delta_c;
    logic         idx_rise_c;

    logic [1:0]   prev_phase_q, prev_phase_d;
    logic         idx_prev_q, idx_prev_d;
    logic         primed_q, primed_d;
    logic [1:0]   s_q, s_d;
    logic         step_q, step_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;
    logic [n-1:0] pos_q, pos_d;

    assign phase_c    = clean_c[2:1];
    assign idx_c      = clean_c[0];
    // 1 = forward, 3 = reverse, 2 = both bits changed, 0 = no change
    assign delta_c    = 2'(gray_pos(phase_c) - gray_pos(prev_phase_q));
    assign idx_rise_c = idx_c & ~idx_prev_q;

    // Command decode; index clear outranks a coincident step
    always_comb begin
        s_d          = S_HOLD;
        step_d       = 1'b0;
        dir_d        = dir_q;
        err_d        = err_q & ~err_clr;
        pos_d        = pos_q;
        prev_phase_d = phase_c;
        idx_prev_d   = idx_c;
        primed_d     = 1'b1;

        if (primed_q) begin
            if (delta_c == 2'd2) begin
                err_d = 1'b1;
            end
            if (EN) begin
                if (idx_rise_c) begin
                    s_d   = S_CLEAR;
                    pos_d = '0;
                end else if (delta_c == 2'd1) begin
                    s_d    = S_UP;
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    pos_d  = pos_q + n'(1);
                end else if (delta_c == 2'd3) begin
                    s_d    = S_DOWN;
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    pos_d  = pos_q - n'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q          <= S_HOLD;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            err_q        <= 1'b0;
            pos_q        <= '0;
            prev_phase_q <= '0;
            idx_prev_q   <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            s_q          <= s_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            err_q        <= err_d;
            pos_q        <= pos_d;
            prev_phase_q <= prev_phase_d;
            idx_prev_q   <= idx_prev_d;
            primed_q     <= primed_d;
        end
    end

    assign s    = s_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder
//   Drives directed encoder scenarios followed by randomized quadrature
//   traffic and compares every cycle against a behavioural model that
//   tracks the pin history and the Gray-order rules.
module tb_quad_step_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_i, b_i, idx_i, en_i, clr_i;
    logic [1:0]  s;
    logic        step, dir, err;
    logic [15:0] pos;

    quad_step_decoder #(.n(16), .FILT(4)) dut (
        .CLK(CLK), .RST(RST), .A(a_i), .B(b_i), .IDX(idx_i), .EN(en_i),
        .err_clr(clr_i), .s(s), .step(step), .dir(dir), .err(err), .pos(pos)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Forward Gray order of phase {A,B}
    int order [4] = '{0, 1, 3, 2};

    function automatic int where(input int ph);
        for (int i = 0; i < 4; i++) if (order[i] == ph) return i;
        return 0;
    endfunction

    // Model state
    logic [2:0] pq[$];
    bit  m_primed;
    int  m_prev, m_idxp, m_s, m_step, m_dir, m_err, m_pos;
    int  step_cnt;
    bit  saw_clear;
    int  cur_ph;

    task automatic model_reset();
        pq.delete();
        m_primed = 0; m_prev = 0; m_idxp = 0;
        m_s = 2; m_step = 0; m_dir = 0; m_err = 0; m_pos = 0;
    endtask

    task automatic model_edge();
        int seen, ph, ix, d;
        pq.push_back({a_i, b_i, idx_i});
        if (pq.size() > 4) void'(pq.pop_front());
        seen = (pq.size() >= 3) ? int'(pq[pq.size()-3]) : 0;
        ph = seen >> 1;
        ix = seen & 1;
        m_s = 2; m_step = 0;
        if (m_primed) begin
            d = (where(ph) - where(m_prev) + 4) % 4;
            if (d == 2) m_err = 1;
            else if (clr_i) m_err = 0;
            if (en_i) begin
                if (ix == 1 && m_idxp == 0) begin
                    m_s = 3; m_pos = 0;
                end else if (d == 1) begin
                    m_s = 0; m_step = 1; m_dir = 0; m_pos = (m_pos + 1) % 65536;
                end else if (d == 3) begin
                    m_s = 1; m_step = 1; m_dir = 1; m_pos = (m_pos + 65535) % 65536;
                end
            end
        end
        m_primed = 1;
        m_prev = ph;
        m_idxp = ix;
    endtask

    // One clock: update model at the edge, compare just after it, return at negedge
    task automatic tick();
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        #1;
        chk("s",    int'(s),    m_s);
        chk("step", int'(step), m_step);
        chk("dir",  int'(dir),  m_dir);
        chk("err",  int'(err),  m_err);
        chk("pos",  int'(pos),  m_pos);
        if (step) step_cnt++;
        if (s == 2'd3) saw_clear = 1;
        @(negedge CLK);
    endtask

    task automatic set_ph(input int ph);
        cur_ph = ph;
        a_i = ph[1];
        b_i = ph[0];
    endtask

    task automatic hold(input int ph, input int cycles);
        set_ph(ph);
        repeat (cycles) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_s",   int'(s),   2);
        chk("rst_pos", int'(pos), 0);
        chk("rst_err", int'(err), 0);
        repeat (2) tick();
        RST = 1'b0;
    endtask

    initial begin
        int r, nxt;
        RST = 1'b1; a_i = 0; b_i = 0; idx_i = 0; en_i = 1; clr_i = 0;
        cur_ph = 0; step_cnt = 0; saw_clear = 0;
        model_reset();
        @(negedge CLK);

        // T1: full forward cycle
        do_reset();
        step_cnt = 0;
        hold(0, 8); hold(1, 8); hold(3, 8); hold(2, 8); hold(0, 8);
        chk("t1_steps", step_cnt, 4);
        chk("t1_pos", int'(pos), 4);
        chk("t1_dir", int'(dir), 0);

        // T2: reverse step from zero wraps
        do_reset();
        hold(0, 8); hold(2, 8);
        chk("t2_pos", int'(pos), 16'hFFFF);
        chk("t2_dir", int'(dir), 1);

        // T3: illegal jump, then clear
        hold(0, 8); hold(3, 8);
        chk("t3_err", int'(err), 1);
        chk("t3_pos", int'(pos), 0);
        clr_i = 1; tick(); clr_i = 0; tick();
        chk("t3_clr", int'(err), 0);

        // T4: index coincides with a forward step at pos 7
        do_reset();
        hold(0, 4);
        for (int i = 1; i <= 7; i++) hold(order[i % 4], 3);
        chk("t4_pos7", int'(pos), 7);
        saw_clear = 0; step_cnt = 0;
        idx_i = 1;
        hold(order[0], 6);
        idx_i = 0;
        hold(order[0], 3);
        chk("t4_clear", int'(saw_clear), 1);
        chk("t4_nostep", step_cnt, 0);
        chk("t4_pos", int'(pos), 0);

        // T5: disabled across three forward steps
        step_cnt = 0;
        en_i = 0;
        for (int i = 1; i <= 3; i++) hold(order[i], 4);
        en_i = 1;
        hold(order[3], 6);
        chk("t5_steps", step_cnt, 0);
        chk("t5_pos", int'(pos), 0);

        // T6: two-cycle glitch on A starting from phase 01
        hold(1, 6);
        r = int'(pos);
        step_cnt = 0;
        hold(3, 2); hold(1, 8);
        chk("t6_pos", int'(pos), r);
        chk("t6_steps", step_cnt, 2);

        // Randomized traffic with occasional mid-run reset
        for (int seg = 0; seg < 400; seg++) begin
            if (seg % 100 == 50) do_reset();
            r = int'($urandom_range(0, 99));
            if (r < 40)      nxt = order[(where(cur_ph) + 1) % 4];
            else if (r < 75) nxt = order[(where(cur_ph) + 3) % 4];
            else if (r < 80) nxt = cur_ph ^ 3;
            else             nxt = cur_ph;
            en_i  = ($urandom_range(0, 9) != 0);
            idx_i = ($urandom_range(0, 7) == 0);
            clr_i = ($urandom_range(0, 5) == 0);
            hold(nxt, int'($urandom_range(2, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
